// File: rtl/spi_fsm_pkg.sv
// spi_fsm_pkg: state encoding, R/W bit meaning and counter sizing for the SPI burst FSM
package spi_fsm_pkg;
  typedef enum logic [3:0] {
    IDLE, GET_ADDR, GOT_ADDR, READ_LOAD, READ_SHIFT,
    ADDR_INC_R, WRITE_SHIFT, WRITE_COMMIT, ADDR_INC_W, DONE
  } state_t;
  localparam logic RW_READ = 1'b1;
  function automatic int cnt_width(int addr_w, int data_w);
    return $clog2((addr_w + 1 > data_w ? addr_w + 1 : data_w) + 1);
  endfunction
endpackage

// File: rtl/spi_bit_counter.sv
// spi_bit_counter: clearable edge counter flagging the edge that reaches the terminal count
module spi_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         hit
);
  logic [W-1:0] count;
  always_ff @(posedge clk) begin
    if (reset || clr) count <= '0;
    else if (en) count <= count + W'(1);
  end
  // term is one below the target, so hit marks the edge that completes the field
  assign hit = en && count == term;
endmodule

// File: rtl/spi_burst_fsm.sv
// spi_burst_fsm: SPI slave control FSM with address/R-W/data framing, burst and abort on CS release
module spi_burst_fsm
  import spi_fsm_pkg::*;
#(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter bit BURST_EN = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic clkedge,
  input  logic cs,
  input  logic sout,
  output logic ADDR_WE,
  output logic DM_WE,
  output logic BUF_WE,
  output logic SR_WE,
  output logic ADDR_INC,
  output logic busy
);
  localparam int CW = cnt_width(ADDR_W, DATA_W);
  state_t state, next;
  logic counting, hit;
  logic [CW-1:0] term;
  assign counting = state inside {GET_ADDR, READ_SHIFT, WRITE_SHIFT};
  assign term = state == GET_ADDR ? CW'(ADDR_W) : CW'(DATA_W - 1);
  spi_bit_counter #(.W(CW)) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (next != state),
    .en   (counting && clkedge),
    .term (term),
    .hit  (hit)
  );
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = state;
    // a started commit always finishes its DM_WE pulse before honouring cs release
    if (cs && state != IDLE && state != WRITE_COMMIT) next = IDLE;
    else begin
      unique case (state)
        IDLE:         next = cs ? IDLE : GET_ADDR;
        GET_ADDR:     next = hit ? GOT_ADDR : GET_ADDR;
        GOT_ADDR:     next = sout == RW_READ ? READ_LOAD : WRITE_SHIFT;
        READ_LOAD:    next = READ_SHIFT;
        READ_SHIFT:   next = hit ? (BURST_EN ? ADDR_INC_R : DONE) : READ_SHIFT;
        ADDR_INC_R:   next = READ_LOAD;
        WRITE_SHIFT:  next = hit ? WRITE_COMMIT : WRITE_SHIFT;
        WRITE_COMMIT: next = cs ? IDLE : (BURST_EN ? ADDR_INC_W : DONE);
        ADDR_INC_W:   next = WRITE_SHIFT;
        DONE:         next = DONE;
        default:      next = IDLE;
      endcase
    end
  end
  always_comb begin
    ADDR_WE  = state == GOT_ADDR;
    DM_WE    = state == WRITE_COMMIT;
    SR_WE    = state == READ_LOAD;
    ADDR_INC = state == ADDR_INC_R || state == ADDR_INC_W;
    BUF_WE   = state == READ_SHIFT || state == ADDR_INC_R;
    busy     = state != IDLE;
  end
endmodule

// File: tb/tb_spi_burst_fsm.sv
// tb_spi_burst_fsm: random and directed frames on burst and single-word instances against a timeline model
module tb_spi_burst_fsm;
  import spi_fsm_pkg::*;
  logic clk = 1'b0, reset, clkedge, cs, sout;
  logic aw_b, dm_b, buf_b, sr_b, inc_b, busy_b;
  logic aw_n, dm_n, buf_n, sr_n, inc_n, busy_n;
  logic [5:0] vb, vn;
  bit [5:0] exp_v [2][65536];
  bit edge_at [65536];
  int cyc = 0, n_chk = 0, n_err = 0;
  bit chk_on = 1'b0;
  always #5 clk = ~clk;
  spi_burst_fsm #(.ADDR_W(7), .DATA_W(8), .BURST_EN(1'b1)) dut_b (
    .clk(clk), .reset(reset), .clkedge(clkedge), .cs(cs), .sout(sout),
    .ADDR_WE(aw_b), .DM_WE(dm_b), .BUF_WE(buf_b), .SR_WE(sr_b), .ADDR_INC(inc_b), .busy(busy_b)
  );
  spi_burst_fsm #(.ADDR_W(7), .DATA_W(8), .BURST_EN(1'b0)) dut_n (
    .clk(clk), .reset(reset), .clkedge(clkedge), .cs(cs), .sout(sout),
    .ADDR_WE(aw_n), .DM_WE(dm_n), .BUF_WE(buf_n), .SR_WE(sr_n), .ADDR_INC(inc_n), .busy(busy_n)
  );
  assign vb = {aw_b, dm_b, buf_b, sr_b, inc_b, busy_b};
  assign vn = {aw_n, dm_n, buf_n, sr_n, inc_n, busy_n};
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic put(int b, int c, int k, int r);
    if (c <= r) exp_v[b][c][k] = 1'b1;
  endtask
  // Expected output bits {ADDR_WE,DM_WE,BUF_WE,SR_WE,ADDR_INC,busy} per cycle, from edge times
  task automatic frame(bit rw, int n, int d);
    int e[41];
    int c0, r, words, hi, sr_cyc;
    c0 = cyc + 1;
    e[0] = 0;
    for (int j = 1; j <= n; j++) begin
      e[j] = (j == 1) ? c0 + 1 + int'($urandom_range(0, 3)) : e[j-1] + int'($urandom_range(4, 6));
      edge_at[e[j]] = 1'b1;
    end
    r = (n > 0 ? e[n] : c0 + 1) + d;
    sr_cyc = n >= 8 ? e[8] + 1 : -1;
    for (int b = 0; b < 2; b++) begin
      for (int c = c0 + 1; c <= r; c++) put(b, c, 0, r);
      if (n >= 8) begin
        put(b, e[8] + 1, 5, r);
        words = (n - 8) / 8;
        if (b == 0 && words > 1) words = 1;
        if (!rw) begin
          for (int j = 1; j <= words; j++) begin
            put(b, e[8+8*j] + 1, 4, r);
            if (b == 1) put(b, e[8+8*j] + 2, 1, r);
          end
        end else begin
          put(b, e[8] + 2, 2, r);
          hi = (b == 0 && n >= 16) ? e[16] : r;
          for (int c = e[8] + 3; c <= hi; c++) put(b, c, 3, r);
          if (b == 1)
            for (int j = 1; j <= words; j++) begin
              put(b, e[8+8*j] + 1, 1, r);
              put(b, e[8+8*j] + 2, 2, r);
              exp_v[b][e[8+8*j] + 2][3] = 1'b0;
            end
        end
      end
    end
    for (int c = c0; c <= r + 1; c++) begin
      tick();
      cs = c >= r;
      clkedge = edge_at[c];
      sout = (c == sr_cyc) ? rw : 1'($urandom);
    end
  endtask
  always @(negedge clk)
    if (chk_on) begin
      check("burst_out", 32'(vb), 32'(exp_v[1][cyc]));
      check("single_out", 32'(vn), 32'(exp_v[0][cyc]));
    end
  initial begin
    reset = 1'b1; cs = 1'b1; clkedge = 1'b0; sout = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    cs = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      clkedge = 1'b1;
      tick();
      clkedge = 1'b0;
      repeat (3) tick();
    end
    check("pre_reset_count", 32'(dut_b.u_cnt.count), 32'd5);
    check("pre_reset_busy", 32'({busy_b, busy_n}), 32'b11);
    reset = 1'b1; clkedge = 1'b1;
    tick();
    tick();
    check("reset_state", 32'(dut_b.state), 32'(IDLE));
    check("reset_count", 32'(dut_b.u_cnt.count), 32'd0);
    check("reset_out_b", 32'(vb), 32'd0);
    check("reset_out_n", 32'(vn), 32'd0);
    reset = 1'b0; cs = 1'b1; clkedge = 1'b0;
    tick();
    check("post_reset_state", 32'(dut_n.state), 32'(IDLE));
    chk_on = 1'b1;
    frame(1'b0, 16, 3);
    frame(1'b1, 16, 3);
    frame(1'b0, 32, 2);
    frame(1'b0, 12, 2);
    frame(1'b0, 16, 2);
    frame(1'b0, 16, 1);
    frame(1'b1, 32, 1);
    frame(1'b1, 24, 2);
    frame(1'b0, 8, 1);
    frame(1'b1, 0, 3);
    repeat (40) frame(1'($urandom), int'($urandom_range(0, 40)), int'($urandom_range(1, 6)));
    repeat (4) tick();
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
